// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues dmem req/ack accesses, drives stall/flush, registers MEM/WB bundle.
// Optional feature macro MEM_TIMEOUT_EN: abort a BUSY access after TIMEOUT cycles without dmem_ack.
module mem_stage_ctrl #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              RegWrite_in,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic [2:0]        MemToReg_in,
    input  logic              Branch_in,
    input  logic              Zero_in,
    input  logic [2:0]        jump_in,
    input  logic [DATA_W-1:0] ALUResult_in,
    input  logic [DATA_W-1:0] WriteMemData_in,
    input  logic [REG_W-1:0]  WriteReg_in,
    input  logic [DATA_W-1:0] pc_plus_4_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              stall,
    output logic              flush,
    output logic              wb_valid,
    output logic              RegWrite_wb,
    output logic [2:0]        MemToReg_wb,
    output logic [REG_W-1:0]  WriteReg_wb,
    output logic [DATA_W-1:0] ALUResult_wb,
    output logic [DATA_W-1:0] ReadData_wb,
    output logic [DATA_W-1:0] pc_plus_4_wb,
    output logic              err_timeout
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_stage_ctrl: TIMEOUT must be at least 1");
    end

    typedef enum logic [0:0] {StIdle, StBusy} state_t;

    state_t r_state;
    state_t w_state_d;

    logic              w_memop;
    logic              w_load;
    logic              w_redirect;
    logic              w_issue;
    logic              w_retire;
    logic              w_abort;
    logic              w_timeout;

    logic              r_dmem_req;
    logic              r_dmem_we;
    logic [DATA_W-1:0] r_dmem_addr;
    logic [DATA_W-1:0] r_dmem_wdata;
    logic              r_flush;
    logic              r_wb_valid;
    logic              r_regwrite_wb;
    logic [2:0]        r_memtoreg_wb;
    logic [REG_W-1:0]  r_writereg_wb;
    logic [DATA_W-1:0] r_aluresult_wb;
    logic [DATA_W-1:0] r_readdata_wb;
    logic [DATA_W-1:0] r_pc_plus_4_wb;

    assign w_memop    = in_valid & (MemRead_in | MemWrite_in);
    // A load with MemWrite also set is treated as a store.
    assign w_load     = MemRead_in & ~MemWrite_in;
    assign w_redirect = (Branch_in & Zero_in) | (|jump_in);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err_timeout;

    // r_cnt holds the number of BUSY cycles already spent before the current one.
    assign w_timeout = (r_state == StBusy) & ~dmem_ack & (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            if (w_issue) begin
                r_cnt <= '0;
            end else if (r_state == StBusy) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_abort) begin
                r_err_timeout <= 1'b1;
            end
        end
    end

    assign err_timeout = r_err_timeout;
`else
    assign w_timeout   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_comb begin
        w_state_d = r_state;
        w_issue   = 1'b0;
        w_retire  = 1'b0;
        w_abort   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_memop) begin
                    w_issue   = 1'b1;
                    w_state_d = StBusy;
                end else if (in_valid) begin
                    w_retire = 1'b1;
                end
            end
            StBusy: begin
                if (dmem_ack) begin
                    w_retire  = 1'b1;
                    w_state_d = StIdle;
                end else if (w_timeout) begin
                    w_abort   = 1'b1;
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Gated by rst_n so the upstream pipeline is released as soon as reset asserts.
    assign stall = rst_n & w_memop & ~((r_state == StBusy) & dmem_ack) & ~w_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_issue) begin
                r_dmem_req   <= 1'b1;
                r_dmem_we    <= MemWrite_in;
                r_dmem_addr  <= ALUResult_in;
                r_dmem_wdata <= WriteMemData_in;
            end else if (w_retire || w_abort) begin
                r_dmem_req <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush        <= 1'b0;
            r_wb_valid     <= 1'b0;
            r_regwrite_wb  <= 1'b0;
            r_memtoreg_wb  <= '0;
            r_writereg_wb  <= '0;
            r_aluresult_wb <= '0;
            r_readdata_wb  <= '0;
            r_pc_plus_4_wb <= '0;
        end else begin
            r_flush       <= w_retire & w_redirect;
            r_wb_valid    <= w_retire;
            r_regwrite_wb <= w_retire & RegWrite_in;
            if (w_retire) begin
                r_memtoreg_wb  <= MemToReg_in;
                r_writereg_wb  <= WriteReg_in;
                r_aluresult_wb <= ALUResult_in;
                r_pc_plus_4_wb <= pc_plus_4_in;
                r_readdata_wb  <= ((r_state == StBusy) && w_load) ? dmem_rdata : '0;
            end
        end
    end

    assign dmem_req     = r_dmem_req;
    assign dmem_we      = r_dmem_we;
    assign dmem_addr    = r_dmem_addr;
    assign dmem_wdata   = r_dmem_wdata;
    assign flush        = r_flush;
    assign wb_valid     = r_wb_valid;
    assign RegWrite_wb  = r_regwrite_wb;
    assign MemToReg_wb  = r_memtoreg_wb;
    assign WriteReg_wb  = r_writereg_wb;
    assign ALUResult_wb = r_aluresult_wb;
    assign ReadData_wb  = r_readdata_wb;
    assign pc_plus_4_wb = r_pc_plus_4_wb;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed cases plus randomized instruction stream
// checked against a per-instruction timeline model (memop with ack delay d occupies d+2 cycles).
`timescale 1ns/1ps
module tb_mem_stage_ctrl;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int TO     = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, RegWrite_in, MemRead_in, MemWrite_in;
    logic [2:0]        MemToReg_in;
    logic              Branch_in, Zero_in;
    logic [2:0]        jump_in;
    logic [DATA_W-1:0] ALUResult_in, WriteMemData_in, pc_plus_4_in;
    logic [REG_W-1:0]  WriteReg_in;
    logic              dmem_req, dmem_we, dmem_ack;
    logic [DATA_W-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic              stall, flush, wb_valid, RegWrite_wb, err_timeout;
    logic [2:0]        MemToReg_wb;
    logic [REG_W-1:0]  WriteReg_wb;
    logic [DATA_W-1:0] ALUResult_wb, ReadData_wb, pc_plus_4_wb;

    mem_stage_ctrl #(.DATA_W(DATA_W), .REG_W(REG_W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .RegWrite_in(RegWrite_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .MemToReg_in(MemToReg_in),
        .Branch_in(Branch_in), .Zero_in(Zero_in), .jump_in(jump_in),
        .ALUResult_in(ALUResult_in), .WriteMemData_in(WriteMemData_in),
        .WriteReg_in(WriteReg_in), .pc_plus_4_in(pc_plus_4_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall), .flush(flush), .wb_valid(wb_valid), .RegWrite_wb(RegWrite_wb),
        .MemToReg_wb(MemToReg_wb), .WriteReg_wb(WriteReg_wb), .ALUResult_wb(ALUResult_wb),
        .ReadData_wb(ReadData_wb), .pc_plus_4_wb(pc_plus_4_wb), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected MEM/WB contents produced by the most recently completed instruction slot.
    logic              e_valid, e_rw, e_flush, e_err;
    logic [2:0]        e_m2r;
    logic [REG_W-1:0]  e_wr;
    logic [DATA_W-1:0] e_alu, e_rd, e_pc4;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_pending();
        e_valid = 1'b0; e_rw = 1'b0; e_flush = 1'b0;
        e_m2r = '0; e_wr = '0; e_alu = '0; e_rd = '0; e_pc4 = '0;
    endtask

    // Drives one EX/MEM slot (held while stalled); d = ack delay after dmem_req rises.
    task automatic run_instr(input logic v, input logic rw, input logic mr, input logic mw,
                             input logic br, input logic z, input logic [2:0] jmp,
                             input logic [2:0] m2r, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [4:0] wr,
                             input logic [31:0] pc4, input int d, input logic early_ack,
                             input logic [31:0] rdata);
        logic memop;
        int   ncyc;
        memop = v & (mr | mw);
        ncyc  = memop ? d + 2 : 1;
        in_valid = v; RegWrite_in = rw; MemRead_in = mr; MemWrite_in = mw;
        Branch_in = br; Zero_in = z; jump_in = jmp; MemToReg_in = m2r;
        ALUResult_in = addr; WriteMemData_in = wd; WriteReg_in = wr; pc_plus_4_in = pc4;
        for (int c = 0; c < ncyc; c++) begin
            if (c == 0) dmem_ack = early_ack;
            else        dmem_ack = (c == d + 1);
            dmem_rdata = dmem_ack && c > 0 ? rdata : $urandom;
            @(negedge clk);
            chk("stall", 32'(stall), 32'(memop && c <= d));
            chk("dmem_req", 32'(dmem_req), 32'(memop && c >= 1));
            chk("err_timeout", 32'(err_timeout), 32'(e_err));
            if (memop && c >= 1) begin
                chk("dmem_we", 32'(dmem_we), 32'(mw));
                chk("dmem_addr", dmem_addr, addr);
                if (mw) chk("dmem_wdata", dmem_wdata, wd);
            end
            if (c == 0) begin
                chk("wb_valid", 32'(wb_valid), 32'(e_valid));
                chk("RegWrite_wb", 32'(RegWrite_wb), 32'(e_rw));
                chk("flush", 32'(flush), 32'(e_flush));
                if (e_valid) begin
                    chk("MemToReg_wb", 32'(MemToReg_wb), 32'(e_m2r));
                    chk("WriteReg_wb", 32'(WriteReg_wb), 32'(e_wr));
                    chk("ALUResult_wb", ALUResult_wb, e_alu);
                    chk("ReadData_wb", ReadData_wb, e_rd);
                    chk("pc_plus_4_wb", pc_plus_4_wb, e_pc4);
                end
            end else begin
                chk("wb_valid_bubble", 32'(wb_valid), 32'd0);
                chk("flush_bubble", 32'(flush), 32'd0);
            end
            @(posedge clk); #1;
        end
        dmem_ack = 1'b0;
        e_valid = v; e_rw = v & rw; e_m2r = m2r; e_wr = wr; e_alu = addr; e_pc4 = pc4;
        e_rd    = (memop && mr && !mw) ? rdata : 32'd0;
        e_flush = v & ((br & z) | (jmp != 3'b000));
    endtask

    task automatic run_random(input int n);
        int kind;
        logic mr, mw, br, rw;
        logic [2:0] jmp;
        for (int i = 0; i < n; i++) begin
            kind = int'($urandom_range(0, 5));
            mr = (kind == 2) || (kind == 5 && $urandom_range(0, 1) == 1);
            mw = (kind == 3) || (kind == 5 && $urandom_range(0, 1) == 1);
            br = (kind == 4) || (kind == 5);
            jmp = (kind == 5 && $urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : 3'b000;
            rw = 1'($urandom_range(0, 1));
            run_instr(kind != 0, rw, mr, mw, br, 1'($urandom_range(0, 1)), jmp,
                      3'($urandom_range(0, 7)), $urandom, $urandom,
                      5'($urandom_range(0, 31)), $urandom, int'($urandom_range(0, 5)),
                      $urandom_range(0, 3) == 0, $urandom);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 0; RegWrite_in = 0; MemRead_in = 0; MemWrite_in = 0; MemToReg_in = 0;
        Branch_in = 0; Zero_in = 0; jump_in = 0; ALUResult_in = 0; WriteMemData_in = 0;
        WriteReg_in = 0; pc_plus_4_in = 0; dmem_ack = 0; dmem_rdata = 0;
        e_err = 1'b0;
        clear_pending();
        #12;
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_ALUResult_wb", ALUResult_wb, 32'd0);
        chk("rst_err_timeout", 32'(err_timeout), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // ALU op, load with 3-cycle ack delay, store with immediate ack
        run_instr(1, 1, 0, 0, 0, 0, 3'd0, 3'd1, 32'h10, 32'h0, 5'd5, 32'h104, 0, 0, 32'h0);
        run_instr(1, 1, 1, 0, 0, 0, 3'd0, 3'd2, 32'h40, 32'h0, 5'd7, 32'h108, 3, 0,
                  32'hDEAD_BEEF);
        run_instr(1, 0, 0, 1, 0, 0, 3'd0, 3'd0, 32'h80, 32'h1234, 5'd0, 32'h10C, 0, 1,
                  32'h5555_AAAA);
        // read+write together counts as a write
        run_instr(1, 1, 1, 1, 0, 0, 3'd0, 3'd2, 32'hC0, 32'h77, 5'd9, 32'h110, 1, 0,
                  32'hFFFF_0000);
        // branch taken / not taken / jump
        run_instr(1, 0, 0, 0, 1, 1, 3'd0, 3'd0, 32'h0, 32'h0, 5'd0, 32'h114, 0, 0, 32'h0);
        run_instr(1, 0, 0, 0, 1, 0, 3'd0, 3'd0, 32'h0, 32'h0, 5'd0, 32'h118, 0, 0, 32'h0);
        run_instr(1, 1, 0, 0, 0, 0, 3'd1, 3'd3, 32'h0, 32'h0, 5'd31, 32'h11C, 0, 1, 32'h0);
        run_instr(0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 32'h0, 32'h0, 5'd0, 32'h0, 0, 0, 32'h0);
        run_instr(0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 32'h0, 32'h0, 5'd0, 32'h0, 0, 0, 32'h0);

        run_random(40);

`ifdef MEM_TIMEOUT_EN
        // Load with no ack: aborted in the TO-th BUSY cycle, dropped as a bubble.
        run_instr(0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 32'h0, 32'h0, 5'd0, 32'h0, 0, 0, 32'h0);
        in_valid = 1; RegWrite_in = 1; MemRead_in = 1; MemWrite_in = 0; Branch_in = 1;
        Zero_in = 1; jump_in = 0; ALUResult_in = 32'h200; dmem_ack = 0;
        for (int c = 0; c <= TO; c++) begin
            @(negedge clk);
            chk("to_stall", 32'(stall), 32'(c < TO));
            chk("to_dmem_req", 32'(dmem_req), 32'(c >= 1));
            chk("to_err_early", 32'(err_timeout), 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 0; MemRead_in = 0; Branch_in = 0; Zero_in = 0;
        @(negedge clk);
        chk("to_req_drop", 32'(dmem_req), 32'd0);
        chk("to_wb_valid", 32'(wb_valid), 32'd0);
        chk("to_flush", 32'(flush), 32'd0);
        chk("to_err_set", 32'(err_timeout), 32'd1);
        @(posedge clk); #1;
        e_err = 1'b1;
        clear_pending();
        run_random(8);
`else
        // Long wait without timeout support: access still completes normally.
        run_instr(1, 1, 1, 0, 0, 0, 3'd0, 3'd2, 32'h300, 32'h0, 5'd12, 32'h400, 20, 0,
                  32'hCAFE_F00D);
`endif

        // Reset while BUSY drops the outstanding request immediately.
        run_instr(0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 32'h0, 32'h0, 5'd0, 32'h0, 0, 0, 32'h0);
        in_valid = 1; RegWrite_in = 1; MemRead_in = 1; MemWrite_in = 0; Branch_in = 0;
        jump_in = 0; ALUResult_in = 32'h100; dmem_ack = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_busy_req", 32'(dmem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_req", 32'(dmem_req), 32'd0);
        chk("rst_async_stall", 32'(stall), 32'd0);
        chk("rst_async_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_async_err", 32'(err_timeout), 32'd0);
        in_valid = 0; MemRead_in = 0; RegWrite_in = 0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        e_err = 1'b0;
        clear_pending();
        // IDLE after reset: one-cycle ALU retire, then store with one stall cycle
        run_instr(1, 1, 0, 0, 0, 0, 3'd0, 3'd4, 32'h55, 32'h0, 5'd3, 32'h500, 0, 0, 32'h0);
        run_instr(1, 0, 0, 1, 0, 0, 3'd0, 3'd0, 32'h84, 32'h99, 5'd0, 32'h504, 0, 0, 32'h0);
        run_random(15);
        run_instr(0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 32'h0, 32'h0, 5'd0, 32'h0, 0, 0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
Consumer end of the EX/MEM pipeline register. Takes the registered EX/MEM bundle and issues data-memory accesses over a req/ack handshake. Stalls the upstream pipeline while an access is outstanding, generates the `flush` pulse back into the earlier pipeline registers on a taken branch or jump, and registers the MEM/WB bundle for write-back.

Parameters:
DATA_W, 32, data/address width
REG_W, 5, register-index width
TIMEOUT, 16, max BUSY cycles waiting for dmem_ack before abort (only used with MEM_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  EX/MEM slot holds a real instruction
RegWrite_in  in  1  write-back enable
MemRead_in  in  1  load
MemWrite_in  in  1  store
MemToReg_in  in  3  write-back mux select, passed through
Branch_in  in  1  branch instruction
Zero_in  in  1  ALU zero flag
jump_in  in  3  jump type, nonzero = jump
ALUResult_in  in  DATA_W  ALU result / memory address
WriteMemData_in  in  DATA_W  store data
WriteReg_in  in  REG_W  destination register
pc_plus_4_in  in  DATA_W  link value
dmem_req  out  1  memory request
dmem_we  out  1  1 = write, 0 = read
dmem_addr  out  DATA_W  memory address
dmem_wdata  out  DATA_W  store data
dmem_ack  in  1  memory completion, single-cycle pulse
dmem_rdata  in  DATA_W  read data, valid when dmem_ack=1
stall  out  1  hold IF/ID, ID/EX, EX/MEM
flush  out  1  one-cycle flush to upstream registers
wb_valid  out  1  MEM/WB slot valid
RegWrite_wb  out  1  gated write-back enable
MemToReg_wb  out  3  registered MemToReg
WriteReg_wb  out  REG_W  registered destination
ALUResult_wb  out  DATA_W  registered ALU result
ReadData_wb  out  DATA_W  captured load data (0 when not a load)
pc_plus_4_wb  out  DATA_W  registered link value
err_timeout  out  1  sticky timeout flag

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; state IDLE; timeout counter 0.
  - Any outstanding request is dropped immediately.
- Definitions:
  - memop = in_valid & (MemRead_in | MemWrite_in).
  - If MemRead_in and MemWrite_in are both set, the access is a write and ReadData_wb = 0.
- FSM states: IDLE, BUSY.
- IDLE, in_valid & !memop: retire this cycle.
  - Next edge: wb_valid=1; WB bundle loaded from inputs; RegWrite_wb = RegWrite_in.
- IDLE, memop: next edge → BUSY.
  - dmem_req=1; dmem_we=MemWrite_in; dmem_addr=ALUResult_in; dmem_wdata=WriteMemData_in.
  - wb_valid=0 that edge (bubble).
- BUSY:
  - dmem_req and its address/data fields are held stable until dmem_ack.
  - On dmem_ack: retire. Next edge: dmem_req=0; ReadData_wb = dmem_rdata for a read, 0 for a write; wb_valid=1; state → IDLE.
- in_valid=0 in IDLE: wb_valid=0 next edge; RegWrite_wb=0.
- stall (combinational) = memop & !(state==BUSY & dmem_ack).
  - Minimum load/store cost is 1 stall cycle when ack arrives in the first BUSY cycle.
- flush:
  - Registered, high exactly one cycle, on the edge after an instruction retires with (Branch_in & Zero_in) | (jump_in != 0).
  - Non-retiring cycles never raise flush.
- dmem_ack outside BUSY: ignored.
- Inputs are assumed stable while stall=1, because the upstream register is held.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - BUSY counts cycles. If the count reaches TIMEOUT without dmem_ack, the next edge sets dmem_req=0, state=IDLE, wb_valid=0 (the instruction is dropped as a bubble), and sets err_timeout=1.
  - err_timeout is cleared only by reset.
  - stall releases on the same cycle the count hits TIMEOUT.
- Undefined:
  - No counter; BUSY waits indefinitely.
  - err_timeout is tied to 0.

Test Plan:
1. ALU op: in_valid=1, RegWrite_in=1, ALUResult_in=0x0000_0010, WriteReg_in=5 → next edge wb_valid=1, ALUResult_wb=0x10, WriteReg_wb=5, stall=0 throughout.
2. Load addr 0x40, ack 3 cycles after dmem_req rises, rdata=0xDEAD_BEEF → stall high 4 cycles, dmem_addr=0x40 held, ReadData_wb=0xDEADBEEF, wb_valid=1 once.
3. Store addr 0x80, data 0x1234 with immediate ack → dmem_we=1, dmem_wdata=0x1234, exactly 1 stall cycle, ReadData_wb=0.
4. Branch_in=1, Zero_in=1, in_valid=1 → flush=1 for exactly one cycle after retire. With Zero_in=0 → flush stays 0. With jump_in=3'b001 → flush=1.
5. rst_n low while BUSY with dmem_req=1 → dmem_req, stall, wb_valid drop to 0 immediately. After release, state is IDLE.
6. MEM_TIMEOUT_EN, TIMEOUT=16, no ack → stall drops after 16 BUSY cycles, err_timeout=1 and stays 1, wb_valid=0.
